lc3_mem_sys: RTL and testbench

Parametrised LC-3 memory subsystem: word-addressed storage plus memory-mapped keyboard, display and machine-control registers behind one request/ready port with a configurable number of wait states. Sits between the LC-3 datapath's MAR/MDR logic and the outside world. It replaces the fixed single-cycle RAM with explicit device registers, character streaming ports and a halt output.

---
 rtl/lc3_mem_sys.sv | 165 ++++++++++++++++
 tb/tb_lc3_mem_sys.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_sys.sv
// LC-3 memory subsystem: word array plus KBSR/KBDR/DSR/DDR/MCR behind one cs/ready port.
// Latency 2+WAIT_STATES cycles from request edge to ready; cs is held by the master until ready.
module lc3_mem_sys #(
    parameter int    DATA_WIDTH  = 16,
    parameter int    ADDR_WIDTH  = 16,
    parameter int    DEPTH       = 65536,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  r_w,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  kbd_valid,
    input  logic [7:0]            kbd_data,
    output logic                  disp_valid,
    output logic [7:0]            disp_data,
    input  logic                  disp_ready,
    output logic                  halt
);

    localparam logic [ADDR_WIDTH-1:0] KBSR_A = ADDR_WIDTH'(16'hFE00);
    localparam logic [ADDR_WIDTH-1:0] KBDR_A = ADDR_WIDTH'(16'hFE02);
    localparam logic [ADDR_WIDTH-1:0] DSR_A  = ADDR_WIDTH'(16'hFE04);
    localparam logic [ADDR_WIDTH-1:0] DDR_A  = ADDR_WIDTH'(16'hFE06);
    localparam logic [ADDR_WIDTH-1:0] MCR_A  = ADDR_WIDTH'(16'hFFFE);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    r_w_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    kbsr_rdy_q, kbsr_ovr_q;
    logic [7:0]              kbdr_q;
    logic                    dsr_rdy_q;
    logic                    disp_valid_q;
    logic [7:0]              disp_data_q;
    logic [15:0]             mcr_q;
    logic                    halt_q;
    logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

    logic                    accept, do_access;
    logic                    is_kbsr, is_kbdr, is_dsr, is_ddr, is_mcr, is_dev, in_mem;
    logic                    mem_we, kbdr_rd, ddr_wr, mcr_wr;
    logic [MEM_AW-1:0]       mem_idx;
    logic [DATA_WIDTH-1:0]   rd_val;

    assign accept = (state_q == IDLE) && cs;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: if (cs) begin
                state_d = BUSY;
                cnt_d   = 4'(WAIT_STATES);
            end
            BUSY: if (cnt_q == 4'd0) begin
                do_access = 1'b1;
                state_d   = ACK;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign is_kbsr = (addr_q == KBSR_A);
    assign is_kbdr = (addr_q == KBDR_A);
    assign is_dsr  = (addr_q == DSR_A);
    assign is_ddr  = (addr_q == DDR_A);
    assign is_mcr  = (addr_q == MCR_A);
    assign is_dev  = is_kbsr | is_kbdr | is_dsr | is_ddr | is_mcr;
    assign in_mem  = !is_dev && ({1'b0, addr_q} < (ADDR_WIDTH+1)'(DEPTH));
    assign mem_idx = addr_q[MEM_AW-1:0];

    assign mem_we  = do_access && r_w_q && in_mem;
    assign kbdr_rd = do_access && !r_w_q && is_kbdr;
    assign ddr_wr  = do_access && r_w_q && is_ddr;
    assign mcr_wr  = do_access && r_w_q && is_mcr;

    // Device registers are 16 bits wide and zero-extend onto the data bus; DDR reads as 0.
    always_comb begin
        rd_val = '0;
        if (is_kbsr)     rd_val = DATA_WIDTH'({kbsr_rdy_q, kbsr_ovr_q, 14'b0});
        else if (is_kbdr) rd_val = DATA_WIDTH'({8'h00, kbdr_q});
        else if (is_dsr)  rd_val = DATA_WIDTH'({dsr_rdy_q, 15'b0});
        else if (is_mcr)  rd_val = DATA_WIDTH'(mcr_q);
        else if (in_mem)  rd_val = mem_q[mem_idx];
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            r_w_q        <= 1'b0;
            data_q       <= '0;
            data_out_q   <= '0;
            kbsr_rdy_q   <= 1'b0;
            kbsr_ovr_q   <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_rdy_q    <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
            mcr_q        <= 16'h8000;
            halt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= addr;
                r_w_q  <= r_w;
                data_q <= data_in;
            end
            if (do_access && !r_w_q) data_out_q <= rd_val;

            // A KBDR read clears status, but a character arriving on the same edge still lands.
            if (kbdr_rd) begin
                kbsr_rdy_q <= kbd_valid;
                kbsr_ovr_q <= 1'b0;
                if (kbd_valid) kbdr_q <= kbd_data;
            end else if (kbd_valid) begin
                if (!kbsr_rdy_q) begin
                    kbdr_q     <= kbd_data;
                    kbsr_rdy_q <= 1'b1;
                end else begin
                    kbsr_ovr_q <= 1'b1;
                end
            end

            disp_valid_q <= ddr_wr && dsr_rdy_q;
            if (ddr_wr && dsr_rdy_q) begin
                disp_data_q <= data_q[7:0];
                dsr_rdy_q   <= 1'b0;
            end else if (!dsr_rdy_q && disp_ready) begin
                dsr_rdy_q <= 1'b1;
            end

            if (mcr_wr) mcr_q <= data_q[15:0];
            halt_q <= ~mcr_q[15];
        end
    end

    assign ready      = (state_q == ACK);
    assign data_out   = data_out_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign halt       = halt_q;

endmodule

// File: tb/tb_lc3_mem_sys.sv
// Directed bench: two instances (WAIT_STATES=0 full depth, WAIT_STATES=3 with DEPTH=0x4000).
module tb_lc3_mem_sys;

    logic        clk = 1'b0;
    logic        rst_n, cs0, cs3, r_w;
    logic [15:0] addr, data_in;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        disp_ready;
    logic        ready0, ready3, dv0, dv3, halt0, halt3;
    logic [15:0] dout0, dout3;
    logic [7:0]  dd0, dd3;

    int checks = 0;
    int errors = 0;
    int disp_cnt = 0;

    always #5 clk = ~clk;

    lc3_mem_sys #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(65536), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs0), .r_w(r_w), .addr(addr), .data_in(data_in),
        .ready(ready0), .data_out(dout0), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .disp_valid(dv0), .disp_data(dd0), .disp_ready(disp_ready), .halt(halt0));

    lc3_mem_sys #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(16384), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst_n(rst_n), .cs(cs3), .r_w(r_w), .addr(addr), .data_in(data_in),
        .ready(ready3), .data_out(dout3), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .disp_valid(dv3), .disp_data(dd3), .disp_ready(disp_ready), .halt(halt3));

    always @(negedge clk) if (dv0 === 1'b1) disp_cnt++;

    typedef struct {
        bit          d3;
        bit          wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // lat counts falling edges after the request edge until ready is seen.
    task automatic access(input bit d3, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = 16'hxxxx;
        @(negedge clk);
        addr = a; r_w = wr; data_in = wd;
        if (d3) cs3 = 1'b1; else cs0 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((d3 ? ready3 : ready0) === 1'b1) begin
                got = 1'b1;
                rd  = d3 ? dout3 : dout0;
            end
        end
        cs0 = 1'b0;
        cs3 = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr 0x%0h got no ready, expected ready within 40 cycles", a);
            lat = -1;
        end
        @(negedge clk);
        check("ready_one_cycle", d3 ? ready3 : ready0, 1'b0);
    endtask

    task automatic kbd(input logic [7:0] c);
        @(negedge clk);
        kbd_valid = 1'b1;
        kbd_data  = c;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input bit d3, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] rd;
        int lat;
        access(d3, 1'b0, a, 16'h0000, rd, lat);
        check(name, rd, exp);
    endtask

    task automatic wr_do(input bit d3, input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] rd;
        int lat;
        access(d3, 1'b1, a, wd, rd, lat);
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish in time");
    end

    initial begin
        vec_t        tbl[$];
        logic [15:0] rd;
        int          lat;
        int          rdy_seen;

        tbl.push_back('{0, 1, 16'h3000, 16'h1234, 16'h0000, 2});
        tbl.push_back('{0, 0, 16'h3000, 16'h0000, 16'h1234, 2});
        tbl.push_back('{1, 1, 16'h3000, 16'h1234, 16'h0000, 5});
        tbl.push_back('{1, 0, 16'h3000, 16'h0000, 16'h1234, 5});
        tbl.push_back('{0, 0, 16'hFE04, 16'h0000, 16'h8000, 2});
        tbl.push_back('{0, 0, 16'hFE00, 16'h0000, 16'h0000, 2});
        tbl.push_back('{0, 1, 16'hFE00, 16'hFFFF, 16'h0000, 2});
        tbl.push_back('{0, 0, 16'hFE00, 16'h0000, 16'h0000, 2});
        tbl.push_back('{0, 0, 16'hFE06, 16'h0000, 16'h0000, 2});
        tbl.push_back('{0, 0, 16'hFFFE, 16'h0000, 16'h8000, 2});
        tbl.push_back('{0, 1, 16'hFFFE, 16'hC0DE, 16'h0000, 2});
        tbl.push_back('{0, 0, 16'hFFFE, 16'h0000, 16'hC0DE, 2});
        tbl.push_back('{1, 1, 16'h5000, 16'h7777, 16'h0000, 5});
        tbl.push_back('{1, 0, 16'h5000, 16'h0000, 16'h0000, 5});
        tbl.push_back('{1, 1, 16'h3FFF, 16'hA5A5, 16'h0000, 5});
        tbl.push_back('{1, 0, 16'h3FFF, 16'h0000, 16'hA5A5, 5});
        tbl.push_back('{1, 0, 16'hFE04, 16'h0000, 16'h8000, 5});
        tbl.push_back('{0, 1, 16'h0000, 16'h0BAD, 16'h0000, 2});
        tbl.push_back('{0, 0, 16'h0000, 16'h0000, 16'h0BAD, 2});

        rst_n = 1'b0; cs0 = 1'b0; cs3 = 1'b0; r_w = 1'b0;
        addr = 16'h0000; data_in = 16'h0000;
        kbd_valid = 1'b0; kbd_data = 8'h00; disp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready0", ready0, 1'b0);
        check("rst_dout0", dout0, 16'h0000);
        check("rst_dv0", dv0, 1'b0);
        check("rst_dd0", dd0, 8'h00);
        check("rst_halt0", halt0, 1'b0);
        check("rst_ready3", ready3, 1'b0);
        check("rst_dout3", dout3, 16'h0000);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            access(tbl[i].d3, tbl[i].wr, tbl[i].a, tbl[i].wd, rd, lat);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        end
        check("halt_after_mcr_bit15_set", halt0, 1'b0);

        // Keyboard: capture, overrun, clear on KBDR read.
        kbd(8'h41);
        rd_chk("kbsr_after_A", 0, 16'hFE00, 16'h8000);
        kbd(8'h42);
        rd_chk("kbsr_overrun", 0, 16'hFE00, 16'hC000);
        rd_chk("kbdr_keeps_A", 0, 16'hFE02, 16'h0041);
        rd_chk("kbsr_cleared", 0, 16'hFE00, 16'h0000);

        // KBDR read completing on the same edge as a new character.
        kbd(8'h44);
        rd_chk("kbsr_after_D", 0, 16'hFE00, 16'h8000);
        @(negedge clk);
        addr = 16'hFE02; r_w = 1'b0; cs0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kbd_valid = 1'b1; kbd_data = 8'h43;
        check("same_edge_busy", ready0, 1'b0);
        @(negedge clk);
        kbd_valid = 1'b0;
        check("same_edge_ready", ready0, 1'b1);
        check("same_edge_old_data", dout0, 16'h0044);
        cs0 = 1'b0;
        rd_chk("same_edge_kbsr", 0, 16'hFE00, 16'h8000);
        rd_chk("same_edge_kbdr", 0, 16'hFE02, 16'h0043);

        // Display handshake.
        check("disp_none_yet", disp_cnt, 0);
        wr_do(0, 16'hFE06, 16'h0048);
        check("disp_strobe_count", disp_cnt, 1);
        check("disp_data_H", dd0, 8'h48);
        rd_chk("dsr_busy", 0, 16'hFE04, 16'h0000);
        wr_do(0, 16'hFE06, 16'h0055);
        check("disp_dropped_count", disp_cnt, 1);
        check("disp_data_held", dd0, 8'h48);
        @(negedge clk);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        rd_chk("dsr_ready_again", 0, 16'hFE04, 16'h8000);
        wr_do(0, 16'hFE06, 16'h0021);
        check("disp_second_count", disp_cnt, 2);
        check("disp_data_bang", dd0, 8'h21);

        // MCR clear: halt rises one cycle after ready.
        @(negedge clk);
        addr = 16'hFFFE; r_w = 1'b1; data_in = 16'h0000; cs0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mcr_busy_halt", halt0, 1'b0);
        @(negedge clk);
        check("mcr_ready", ready0, 1'b1);
        check("mcr_halt_at_ready", halt0, 1'b0);
        cs0 = 1'b0;
        @(negedge clk);
        check("mcr_halt_after", halt0, 1'b1);
        rd_chk("mcr_read_zero", 0, 16'hFFFE, 16'h0000);
        rd_chk("served_while_halted", 0, 16'h3000, 16'h1234);

        // Reset in the middle of a wait-stated write.
        wr_do(1, 16'h3001, 16'h1111);
        @(negedge clk);
        addr = 16'h3001; r_w = 1'b1; data_in = 16'hDEAD; cs3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        cs3 = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready3 !== 1'b0) rdy_seen++;
        end
        check("abort_no_ready", rdy_seen, 0);
        check("abort_dout3", dout3, 16'h0000);
        check("abort_dv3", dv3, 1'b0);
        check("abort_dd3", dd3, 8'h00);
        check("abort_halt3", halt3, 1'b0);
        check("abort_halt0", halt0, 1'b0);
        check("abort_dd0", dd0, 8'h00);
        rst_n = 1'b1;
        rd_chk("abort_mem_unchanged", 1, 16'h3001, 16'h1111);
        rd_chk("abort_mcr_reset", 0, 16'hFFFE, 16'h8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
